// File: rtl/io_out_fifo_if.sv
// Core-write and downstream-stream signals of the output FIFO.
// The FIFO uses the slave view; the core/peripheral side uses the master view.
interface io_out_fifo_if #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 8,
    parameter int NAW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
);
    // core write port
    logic              out_en;
    logic [NAW-1:0]    addr_out;
    logic [NUBITS-1:0] data_out;
    // show-ahead downstream stream
    logic              m_valid;
    logic              m_ready;
    logic [NAW-1:0]    m_addr;
    logic [NUBITS-1:0] m_data;
    logic [NUIOOU-1:0] m_sel;

    modport slave (
        input  out_en, addr_out, data_out, m_ready,
        output m_valid, m_addr, m_data, m_sel
    );

    modport master (
        output out_en, addr_out, data_out, m_ready,
        input  m_valid, m_addr, m_data, m_sel
    );
endinterface

// File: rtl/io_out_fifo.sv
// Output-side FIFO between the core I/O write port and the peripherals.
// Core writes are never stalled: a write into a full FIFO (with no pop in the
// same cycle) is dropped and counted. Downstream sees a show-ahead stream.
module io_out_fifo #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 16,
    localparam int NAW   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
    localparam int PW    = $clog2(FDEPTH),
    localparam int LW    = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    io_out_fifo_if.slave         bus,
    output logic [LW-1:0]        level,
    output logic                 full,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic [7:0]           drop_cnt
);
    localparam int EW = NAW + NUBITS;

    logic [EW-1:0]  mem_q [FDEPTH];
    logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [7:0]     drop_q, drop_d;

    logic           push, pop, drop, valid;
    logic [NAW-1:0] wr_addr;
    logic [NAW-1:0] head_addr;
    logic [NUIOOU-1:0] sel;

    // Handshake decode and next-state for pointers, occupancy and overflow stats
    always_comb begin
        valid   = (cnt_q != '0);
        full    = (cnt_q == LW'(FDEPTH));
        pop     = valid & bus.m_ready;
        push    = bus.out_en & (~full | pop);
        drop    = bus.out_en & full & ~pop;
        // single-port configuration has no address to carry
        wr_addr = (NUIOOU == 1) ? '0 : bus.addr_out;

        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;

        if (push) wp_d = wp_q + PW'(1);
        if (pop)  rp_d = rp_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + LW'(1);
        else if (pop && !push) cnt_d = cnt_q - LW'(1);

        // clear wins over a drop landing in the same cycle
        if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {wr_addr, bus.data_out};
    end

    // Show-ahead head outputs and one-hot port select
    always_comb begin
        head_addr = mem_q[rp_q][EW-1:NUBITS];
        sel       = '0;
        // addresses beyond the port range match no bit and select nothing
        for (int i = 0; i < NUIOOU; i++)
            sel[i] = valid && (int'(head_addr) == i);
    end

    assign bus.m_valid = valid;
    assign bus.m_addr  = head_addr;
    assign bus.m_data  = mem_q[rp_q][NUBITS-1:0];
    assign bus.m_sel   = sel;
    assign level       = cnt_q;
    assign ovf         = ovf_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_io_out_fifo.sv
// Bench for io_out_fifo: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every falling edge.
module tb_io_out_fifo;
    localparam int NUBITS = 32;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 16;
    localparam int NAW    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ovf_clr;
    logic [4:0] level;
    logic       full, ovf;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    io_out_fifo_if #(.NUBITS(NUBITS), .NUIOOU(NUIOOU)) bus ();

    io_out_fifo #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .level(level), .full(full),
        .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a plain queue of {addr,data} --------
    logic [NAW+NUBITS-1:0] mq[$];
    bit mo_ovf;
    int mo_drop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mo_ovf  = 0;
            mo_drop = 0;
        end else begin
            bit p_pop, p_push, p_drop, p_full;
            p_full = (mq.size() == FDEPTH);
            p_pop  = (mq.size() != 0) && bus.m_ready;
            p_push = bus.out_en && (!p_full || p_pop);
            p_drop = bus.out_en && p_full && !p_pop;
            if (p_pop)  void'(mq.pop_front());
            if (p_push) mq.push_back({bus.addr_out, bus.data_out});
            if (ovf_clr) begin
                mo_ovf = 0; mo_drop = 0;
            end else if (p_drop) begin
                mo_ovf = 1;
                if (mo_drop < 255) mo_drop++;
            end
        end
    end

    // compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("m_valid", bus.m_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("full", full, mq.size() == FDEPTH);
        chk("ovf", ovf, mo_ovf);
        chk("drop_cnt", drop_cnt, mo_drop);
        if (mq.size() != 0) begin
            logic [NAW-1:0] ha;
            ha = mq[0][NAW+NUBITS-1:NUBITS];
            chk("m_addr", bus.m_addr, ha);
            chk("m_data", bus.m_data, mq[0][NUBITS-1:0]);
            chk("m_sel", bus.m_sel, (int'(ha) < NUIOOU) ? (64'd1 << ha) : 64'd0);
        end else begin
            chk("m_sel_idle", bus.m_sel, 0);
        end
    end

    // one clock with the given inputs, returning #1 after the edge
    task automatic step(input bit en, input int a, input int d, input bit rdy, input bit clr);
        bus.out_en   = en;
        bus.addr_out = NAW'(a);
        bus.data_out = NUBITS'(d);
        bus.m_ready  = rdy;
        ovf_clr      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int n = 0;
        while (bus.m_valid && n < 64) begin
            step(0, 0, 0, 1, 0);
            n++;
        end
        chk("drain_bound", bus.m_valid, 0);
    endtask

    initial begin
        int last;
        bus.out_en = 0; bus.addr_out = '0; bus.data_out = '0; bus.m_ready = 0; ovf_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_sel", bus.m_sel, 0);
        chk("rst_full", full, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1;

        // single write, held head, then pop
        step(1, 3, 32'h12345678, 0, 0);
        chk("t1_valid", bus.m_valid, 1);
        chk("t1_addr", bus.m_addr, 3);
        chk("t1_data", bus.m_data, 32'h12345678);
        chk("t1_sel", bus.m_sel, 8'b0000_1000);
        chk("t1_level", level, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk("t1_hold", bus.m_data, 32'h12345678);
        end
        step(0, 0, 0, 1, 0);
        chk("t1_pop_valid", bus.m_valid, 0);
        chk("t1_pop_level", level, 0);

        // fill, overflow one word, drain in order
        for (int i = 0; i < 16; i++) step(1, i % 8, i, 0, 0);
        chk("t2_full", full, 1);
        chk("t2_level", level, 16);
        step(1, 0, 32'h99, 0, 0);
        chk("t2_ovf", ovf, 1);
        chk("t2_drop", drop_cnt, 1);
        chk("t2_level_keep", level, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", bus.m_data, i);
            step(0, 0, 0, 1, 0);
        end
        chk("t2_empty", bus.m_valid, 0);
        step(0, 0, 0, 0, 1);
        chk("t2_clr_ovf", ovf, 0);
        chk("t2_clr_drop", drop_cnt, 0);

        // write into full FIFO together with a pop
        for (int i = 0; i < 16; i++) step(1, 1, 32'h100 + i, 0, 0);
        step(1, 2, 32'hAA, 1, 0);
        chk("t3_level", level, 16);
        chk("t3_ovf", ovf, 0);
        chk("t3_head", bus.m_data, 32'h101);
        last = 0;
        for (int i = 0; i < 16; i++) begin
            last = bus.m_data;
            step(0, 0, 0, 1, 0);
        end
        chk("t3_last", last, 32'hAA);
        chk("t3_empty", bus.m_valid, 0);

        // drop counter saturation and clear-over-drop priority
        for (int i = 0; i < 16; i++) step(1, 0, i, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 32'h55, 0, 0);
        chk("t4_sat", drop_cnt, 255);
        chk("t4_ovf", ovf, 1);
        step(1, 0, 32'h55, 0, 1);
        chk("t4_clr_ovf", ovf, 0);
        chk("t4_clr_drop", drop_cnt, 0);
        step(1, 0, 32'h55, 0, 0);
        chk("t4_after_clr", drop_cnt, 1);
        drain_all();

        // random traffic; the model checks every cycle
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 99) < 50, $urandom_range(0, 499) == 0);
        drain_all();

        // asynchronous reset mid-cycle with queued words
        for (int i = 0; i < 18; i++) step(1, 4, 32'h200 + i, 0, 0);
        chk("t6_pre_level", level, 16);
        chk("t6_pre_ovf", ovf, 1);
        bus.out_en = 0;
        #2 rst = 0;
        #1;
        chk("t6_rst_valid", bus.m_valid, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_ovf", ovf, 0);
        chk("t6_rst_sel", bus.m_sel, 0);
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1;
        step(1, 5, 32'hBEEF, 0, 0);
        chk("t6_new_valid", bus.m_valid, 1);
        chk("t6_new_data", bus.m_data, 32'hBEEF);
        chk("t6_new_addr", bus.m_addr, 5);
        chk("t6_new_level", level, 1);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
